uart_tx: RTL and testbench

- 8N1 UART transmitter that drains the 4-entry TX byte FIFO of the stopwatch UART path.
- Sits directly downstream of the FIFO:
  - watches `fifo_empty` and `fifo_data`.
  - issues a one-cycle `fifo_pop` per byte.
  - serializes the byte onto the `tx` line, timed by an external oversampling baud tick.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_bit_timer.sv | 51 +++++
 rtl/uart_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_tx.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and default
// frame/oversampling parameters used by uart_tx and its bit timer.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS_DEF  = 8;
  localparam int unsigned UART_OVERSAMPLE_DEF = 16;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts baud_tick pulses and strobes bit_end on the
// OVERSAMPLE-th tick after the last restart or bit end.
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   baud_tick - one-clk pulse at OVERSAMPLE x baud rate
//   restart   - holds the tick counter at zero (ticks ignored)
//   bit_end   - combinational strobe, high in the cycle a bit period ends
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic restart,
  output logic bit_end
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  logic [TICK_W-1:0] tick_cnt_q;
  logic [TICK_W-1:0] tick_cnt_d;

  // Wrapping to zero at bit end doubles as the clear on entry to the next bit.
  always_comb begin
    bit_end    = 1'b0;
    tick_cnt_d = tick_cnt_q;
    if (restart) begin
      tick_cnt_d = '0;
    end else if (baud_tick) begin
      if (tick_cnt_q == TICK_LAST) begin
        bit_end    = 1'b1;
        tick_cnt_d = '0;
      end else begin
        tick_cnt_d = tick_cnt_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter draining a byte FIFO onto a serial line (8N1 by default).
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit before stop.
// Ports:
//   clk        - system clock
//   rst        - asynchronous active-low reset
//   baud_tick  - one-clk pulse at OVERSAMPLE x baud rate
//   fifo_empty - FIFO empty flag
//   fifo_data  - FIFO head byte, valid while fifo_empty=0
//   fifo_pop   - one-clk pop strobe, combinational in the IDLE pop cycle
//   tx         - registered serial line, idle high
//   tx_busy    - high from the pop cycle through the end of the stop bit(s)
//   tx_done    - registered one-clk pulse after the final stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS_DEF,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_data,
  output logic                 fifo_pop,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 pop_c;
  logic                 timer_restart;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  uart_bit_timer #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .baud_tick(baud_tick),
    .restart  (timer_restart),
    .bit_end  (bit_end)
  );

  // Next-state, shift/count updates and the line level for the next cycle.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    tx_d          = UART_IDLE_LEVEL;
    done_d        = 1'b0;
    pop_c         = 1'b0;
    timer_restart = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d      = parity_q;
`endif
    case (state_q)
      IDLE: begin
        // Timer held clear so a tick in the pop cycle does not count.
        timer_restart = 1'b1;
        // rst gating keeps the pop low while the block is held in reset.
        if (!fifo_empty && rst) begin
          pop_c     = 1'b1;
          shift_d   = fifo_data;
          bit_cnt_d = '0;
          state_d   = START;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^fifo_data;
`endif
        end
      end
      START: begin
        tx_d = UART_START_LEVEL;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            // Counter is reused to count stop bits.
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = parity_q;
        if (bit_end) begin
          bit_cnt_d = '0;
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        tx_d = UART_IDLE_LEVEL;
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= UART_IDLE_LEVEL;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign fifo_pop = pop_c;
  assign tx_busy  = (state_q != IDLE) || pop_c;
  assign tx       = tx_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: FIFO model, tick-count line model,
// mid-bit sampling receiver and directed plus randomized traffic.
module tb_uart_tx;

  localparam int unsigned OS = 16;
  localparam int unsigned DB = 8;
  localparam int unsigned SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned PB = 1;
`else
  localparam int unsigned PB = 0;
`endif
  localparam int unsigned NB      = 1 + DB + PB + SB;
  localparam int          BIT_CLK = OS * 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_pop;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int pop_count     = 0;
  int done_count    = 0;
  int idle_count    = 0;
  int last_pop_cyc  = -1;
  int last_done_cyc = -1;
  int rx_frames     = 0;
  logic [7:0] last_rx = 8'h00;
  logic       rx_par  = 1'b0;

  logic [7:0] fq[$];
  logic [7:0] push_req[$];
  logic [7:0] exp_rx[$];

  int   run_len[16];
  logic run_lvl[16];

  uart_tx #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OS),
    .STOP_BITS (SB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .tx        (tx),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d want %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Frame levels in line order: start, data LSB first, optional parity, stops.
  function automatic void build_frame(input logic [7:0] d, output logic b[16]);
    for (int i = 0; i < 16; i++) b[i] = 1'b1;
    b[0] = 1'b0;
    for (int i = 0; i < int'(DB); i++) b[1+i] = d[i];
    if (PB != 0) b[1+DB] = ^d;
  endfunction

  task automatic push(input logic [7:0] b, input bit expect_rx);
    push_req.push_back(b);
    if (expect_rx) exp_rx.push_back(b);
  endtask

  // FIFO and baud-tick driver; inputs change 1 time unit after the rising edge.
  initial begin
    logic pop_now;
    int   bcnt;
    baud_tick  = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    bcnt       = 0;
    forever begin
      @(negedge clk);
      pop_now = fifo_pop;
      @(posedge clk);
      #1;
      if (pop_now && fq.size() > 0) void'(fq.pop_front());
      while (push_req.size() > 0 && fq.size() < 4) fq.push_back(push_req.pop_front());
      fifo_empty = (fq.size() == 0);
      fifo_data  = fifo_empty ? 8'h00 : fq[0];
      baud_tick  = (bcnt == 3);
      bcnt       = (bcnt + 1) % 4;
    end
  end

  // Line model: a frame occupies OS*NB counted ticks after its pop cycle; the
  // line shows the bit for the tick count one clk late.
  initial begin
    logic m_active, m_done, m_line, exp_pop;
    logic m_bits[16];
    int   m_ticks;
    m_active = 1'b0;
    m_done   = 1'b0;
    m_line   = 1'b1;
    m_ticks  = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("reset tx", 32'(tx), 32'(1));
        check("reset fifo_pop", 32'(fifo_pop), 32'(0));
        check("reset tx_busy", 32'(tx_busy), 32'(0));
        check("reset tx_done", 32'(tx_done), 32'(0));
        m_active = 1'b0;
        m_done   = 1'b0;
        m_line   = 1'b1;
      end else begin
        exp_pop = !m_active && !fifo_empty;
        check("tx", 32'(tx), 32'(m_line));
        check("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
        check("tx_busy", 32'(tx_busy), 32'(m_active || exp_pop));
        check("tx_done", 32'(tx_done), 32'(m_done));
        if (fifo_pop === 1'b1) begin pop_count++; last_pop_cyc = cyc; end
        if (tx_done === 1'b1) begin done_count++; last_done_cyc = cyc; end
        if (tx_busy === 1'b0) idle_count++;
        m_done = 1'b0;
        if (!m_active) begin
          m_line = 1'b1;
          if (exp_pop) begin
            build_frame(fifo_data, m_bits);
            m_active = 1'b1;
            m_ticks  = 0;
          end
        end else begin
          m_line = m_bits[m_ticks / OS];
          if (baud_tick) begin
            m_ticks++;
            if (m_ticks == int'(OS * NB)) begin
              m_active = 1'b0;
              m_done   = 1'b1;
            end
          end
        end
      end
    end
  end

  // Receiver: start on a falling edge, sample each bit at its middle.
  initial begin
    logic       rx_on, prev_tx;
    logic [7:0] rbyte;
    int         rcnt, idx;
    rx_on   = 1'b0;
    prev_tx = 1'b1;
    rbyte   = 8'h00;
    rcnt    = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        rx_on = 1'b0;
      end else if (!rx_on) begin
        if (tx === 1'b0 && prev_tx === 1'b1) begin
          rx_on = 1'b1;
          rcnt  = 0;
        end
      end else begin
        rcnt++;
        if (rcnt % BIT_CLK == BIT_CLK / 2) begin
          idx = rcnt / BIT_CLK;
          if (idx == 0) begin
            check("rx start bit", 32'(tx), 32'(0));
          end else if (idx <= int'(DB)) begin
            rbyte[idx-1] = tx;
`ifdef UART_TX_PARITY_EN
          end else if (idx == int'(DB) + 1) begin
            rx_par = tx;
            check("rx parity", 32'(tx), 32'(^rbyte));
`endif
          end else begin
            check("rx stop bit", 32'(tx), 32'(1));
            if (idx == int'(NB) - 1) begin
              rx_on   = 1'b0;
              last_rx = rbyte;
              rx_frames++;
              if (exp_rx.size() == 0) check("rx unexpected frame", 32'(rbyte), 32'hFFFF_FFFF);
              else check("rx byte", 32'(rbyte), 32'(exp_rx.pop_front()));
            end
          end
        end
      end
      prev_tx = tx;
    end
  end

  task automatic wait_pop(input int budget, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (fifo_pop !== 1'b1 && n < budget);
    check(name, 32'(fifo_pop), 32'(1));
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (tx_done !== 1'b1 && n < budget);
    check(name, 32'(tx_done), 32'(1));
  endtask

  // Record tx run lengths from the start edge until tx_done.
  task automatic watch_frame(output int frame_len, output int nruns);
    int   fall_c, last_edge, n;
    logic prev;
    fall_c    = -1;
    last_edge = 0;
    nruns     = 0;
    frame_len = 0;
    n         = 0;
    prev      = tx;
    do begin
      @(negedge clk);
      n++;
      if (tx !== prev) begin
        if (fall_c < 0) fall_c = cyc;
        else if (nruns < 16) begin
          run_len[nruns] = cyc - last_edge;
          run_lvl[nruns] = prev;
          nruns++;
        end
        last_edge = cyc;
      end
      prev = tx;
    end while (tx_done !== 1'b1 && n < BIT_CLK * 16);
    check("frame completes", 32'(tx_done), 32'(1));
    if (fall_c >= 0) frame_len = cyc - fall_c;
  endtask

  // Compare recorded runs to the grouped frame levels; the last group merges with idle.
  task automatic check_runs(input logic [7:0] d, input int nruns);
    logic b[16];
    int   g, len;
    build_frame(d, b);
    g   = 0;
    len = 1;
    for (int i = 1; i < int'(NB); i++) begin
      if (b[i] == b[i-1]) len++;
      else begin
        if (g < nruns) begin
          check_range("run length", run_len[g], len * BIT_CLK - 4, len * BIT_CLK + 4);
          check("run level", 32'(run_lvl[g]), 32'(b[i-1]));
        end
        g++;
        len = 1;
      end
    end
    check("run count", 32'(nruns), 32'(g));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int flen, nruns, p0, d0, i0, r0, n;
    rst = 1'b0;
    push(8'h55, 1'b1);
    repeat (5) @(negedge clk);
    check("held reset pop with data", 32'(fifo_pop), 32'(0));
    check("held reset busy", 32'(tx_busy), 32'(0));

    // Single 0x55 frame.
    p0 = pop_count;
    d0 = done_count;
    @(posedge clk); #1 rst = 1'b1;
    watch_frame(flen, nruns);
    check("0x55 run count", 32'(nruns), 32'(9));
    check_runs(8'h55, nruns);
    check_range("0x55 frame length", flen, int'(NB) * BIT_CLK - 4, int'(NB) * BIT_CLK + 4);
    repeat (10) @(negedge clk);
    check("0x55 pops", 32'(pop_count - p0), 32'(1));
    check("0x55 done pulses", 32'(done_count - d0), 32'(1));
    check("0x55 received", 32'(last_rx), 32'h55);

    // Four queued bytes, back to back.
    p0 = pop_count;
    push(8'hA3, 1'b1); push(8'h0F, 1'b1); push(8'hFF, 1'b1); push(8'h00, 1'b1);
    wait_pop(20, "burst first pop");
    i0 = idle_count;
    for (int k = 0; k < 4; k++) wait_done(BIT_CLK * 16, "burst frame done");
    check_range("burst busy gap", idle_count - i0, 0, BIT_CLK);
    check("burst pops", 32'(pop_count - p0), 32'(4));
    check("burst all received", 32'(exp_rx.size()), 32'(0));

    // Long idle with an empty FIFO.
    p0 = pop_count;
    n  = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) n++;
    end
    check("idle line violations", 32'(n), 32'(0));
    check("idle pops", 32'(pop_count - p0), 32'(0));

    // Reset in the middle of 0x3C; 0x81 waits in the FIFO.
    push(8'h3C, 1'b0);
    wait_pop(20, "0x3C pop");
    push(8'h81, 1'b1);
    repeat (BIT_CLK * 3 + 20) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async reset tx", 32'(tx), 32'(1));
    check("async reset busy", 32'(tx_busy), 32'(0));
    r0 = rx_frames;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    p0 = pop_count;
    wait_done(BIT_CLK * 16, "0x81 frame done");
    check("post-reset pops", 32'(pop_count - p0), 32'(1));
    check("post-reset frames", 32'(rx_frames - r0), 32'(1));
    check("post-reset byte", 32'(last_rx), 32'h81);

    // Push during a frame: next pop lands in the tx_done cycle.
    push(8'h5A, 1'b1);
    wait_pop(20, "0x5A pop");
    repeat (200) @(negedge clk);
    push(8'hC3, 1'b1);
    wait_done(BIT_CLK * 16, "0x5A frame done");
    @(negedge clk);
    check("0x5A received", 32'(last_rx), 32'h5A);
    check("next pop in done cycle", 32'(last_pop_cyc), 32'(last_done_cyc));
    wait_done(BIT_CLK * 16, "0xC3 frame done");
    check("0xC3 received", 32'(last_rx), 32'hC3);

    // Bytes 0x07 and 0x03: frame length and parity bit.
    repeat (30) @(negedge clk);
    push(8'h07, 1'b1);
    watch_frame(flen, nruns);
    check_runs(8'h07, nruns);
    check_range("0x07 frame length", flen, int'(NB) * BIT_CLK - 4, int'(NB) * BIT_CLK + 4);
`ifdef UART_TX_PARITY_EN
    check("0x07 parity bit", 32'(rx_par), 32'(1));
`endif
    repeat (30) @(negedge clk);
    push(8'h03, 1'b1);
    watch_frame(flen, nruns);
    check_runs(8'h03, nruns);
    check_range("0x03 frame length", flen, int'(NB) * BIT_CLK - 4, int'(NB) * BIT_CLK + 4);
`ifdef UART_TX_PARITY_EN
    check("0x03 parity bit", 32'(rx_par), 32'(0));
`endif

    // Random bytes at random intervals.
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 150)) @(negedge clk);
      push(8'($urandom_range(0, 255)), 1'b1);
    end
    n = 0;
    while (exp_rx.size() != 0 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("random all received", 32'(exp_rx.size()), 32'(0));
    repeat (BIT_CLK * 2) @(negedge clk);
    check("final idle busy", 32'(tx_busy), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
